// File: rtl/serial_signed_subtractor.sv
// serial_signed_subtractor
//   Bit-serial two's-complement subtractor. Computes a - b one bit per clock,
//   LSB first, with a single full-adder cell fed by a and ~b and a carry
//   seeded to 1. The result is exact at WIDTH+1 bits, with flags for signed
//   overflow of the WIDTH-bit result and for unsigned borrow.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   operand pair on a_i/b_i is valid
//   in_ready_o   block can accept an operand pair (IDLE and not in reset)
//   a_i          minuend, two's complement, WIDTH bits
//   b_i          subtrahend, two's complement, WIDTH bits
//   out_valid_o  result fields are valid
//   out_ready_i  consumer accepts the result
//   diff_o       exact signed difference a - b, WIDTH+1 bits
//   overflow_o   WIDTH-bit truncated difference overflowed (signed)
//   borrow_o     unsigned borrow (inverted carry out of bit WIDTH-1)
module serial_signed_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH:0]   diff_o,
   output logic             overflow_o,
   output logic             borrow_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   // The A register doubles as the result register: each sum bit enters at
   // the MSB while the consumed minuend bit leaves at the LSB.
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   diff_q, diff_d;
   logic             ovf_q, ovf_d;
   logic             brw_q, brw_d;
   logic             valid_q, valid_d;

   logic             sum_bit;
   logic             carry_out;
   logic             last_bit;

   assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
   assign carry_out = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
   assign last_bit  = (cnt_q == CW'(WIDTH - 1));

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      ovf_d   = ovf_q;
      brw_d   = brw_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               a_d     = a_i;
               b_d     = ~b_i;
               carry_d = 1'b1;
               cnt_d   = '0;
               diff_d  = '0;
               ovf_d   = 1'b0;
               brw_d   = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d     = {sum_bit, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            carry_d = carry_out;
            cnt_d   = cnt_q + CW'(1);
            if (last_bit) begin
               // Bit WIDTH is the sum of the sign-extended operand MSBs
               // and the final carry, which makes the result exact.
               diff_d  = {a_q[0] ^ b_q[0] ^ carry_out, sum_bit, a_q[WIDTH-1:1]};
               ovf_d   = carry_q ^ carry_out;
               brw_d   = ~carry_out;
               valid_d = 1'b1;
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready_i) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         ovf_q   <= 1'b0;
         brw_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         ovf_q   <= ovf_d;
         brw_q   <= brw_d;
         valid_q <= valid_d;
      end
   end

   assign in_ready_o  = (state_q == IDLE) & ~rst_i;
   assign out_valid_o = valid_q;
   assign diff_o      = diff_q;
   assign overflow_o  = ovf_q;
   assign borrow_o    = brw_q;

endmodule

// File: tb/tb_serial_signed_subtractor.sv
// Testbench for serial_signed_subtractor (WIDTH = 8): directed vector table,
// randomized operands against an arithmetic reference model, back-pressure
// and reset-mid-operation sequences.
module tb_serial_signed_subtractor;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W:0]   diff;
   logic         ovf;
   logic         brw;

   int checks = 0;
   int errors = 0;

   serial_signed_subtractor #(.WIDTH(W)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .a_i         (a),
      .b_i         (b),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .diff_o      (diff),
      .overflow_o  (ovf),
      .borrow_o    (brw)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W:0]   d;
      logic         o;
      logic         br;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Reference: plain signed/unsigned integer arithmetic on the operands.
   function automatic void model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                 output logic [W:0] d, output logic o, output logic br);
      int ea, eb, ex;
      ea = int'($signed(ta));
      eb = int'($signed(tb_));
      ex = ea - eb;
      d  = ex[W:0];
      o  = (ex > (2**(W-1) - 1)) || (ex < -(2**(W-1)));
      br = (int'(ta) < int'(tb_));
   endfunction

   // Called at a negedge just after the accept edge; returns edges waited.
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
         if (!out_valid) chk("in_ready low while busy", in_ready, 0);
      end
   endtask

   // Full operation with out_ready held high; checks handshake behaviour.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         output logic [W:0] d, output logic o, output logic br);
      int lat;
      @(negedge clk);
      chk("in_ready before accept", in_ready, 1);
      in_valid = 1'b1;
      a = ta;
      b = tb_;
      @(negedge clk);
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      chk("in_ready after accept", in_ready, 0);
      wait_valid(lat);
      chk("latency", lat, W);
      d  = diff;
      o  = ovf;
      br = brw;
      @(negedge clk);
      chk("out_valid after handshake", out_valid, 0);
      chk("in_ready after handshake", in_ready, 1);
   endtask

   initial begin
      vec_t         vecs[7];
      logic [W:0]   d, ed;
      logic         o, eo, br, ebr;
      logic [W-1:0] ra, rb;
      logic [W:0]   held_d;
      logic         held_o, held_b;
      int           lat;

      vecs[0] = '{a: 8'h05, b: 8'h03, d: 9'h002, o: 1'b0, br: 1'b0};
      vecs[1] = '{a: 8'h80, b: 8'h01, d: 9'h17F, o: 1'b1, br: 1'b0};
      vecs[2] = '{a: 8'h00, b: 8'h01, d: 9'h1FF, o: 1'b0, br: 1'b1};
      vecs[3] = '{a: 8'h7F, b: 8'h80, d: 9'h0FF, o: 1'b1, br: 1'b1};
      vecs[4] = '{a: 8'h7F, b: 8'h7F, d: 9'h000, o: 1'b0, br: 1'b0};
      vecs[5] = '{a: 8'h80, b: 8'h7F, d: 9'h101, o: 1'b1, br: 1'b0};
      vecs[6] = '{a: 8'hFF, b: 8'h01, d: 9'h1FE, o: 1'b0, br: 1'b0};

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      a = '0;
      b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset out_valid", out_valid, 0);
      chk("reset diff", diff, 0);
      chk("reset overflow", ovf, 0);
      chk("reset borrow", brw, 0);
      chk("reset in_ready", in_ready, 0);
      rst = 1'b0;
      #1;
      chk("in_ready after release", in_ready, 1);

      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].a, vecs[i].b, d, o, br);
         $display("vec %0d: a=%02h b=%02h diff=%03h ovf=%0b brw=%0b", i, vecs[i].a, vecs[i].b, d, o, br);
         chk("vec diff", d, vecs[i].d);
         chk("vec overflow", o, vecs[i].o);
         chk("vec borrow", br, vecs[i].br);
      end

      for (int i = 0; i < 30; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         model(ra, rb, ed, eo, ebr);
         run_op(ra, rb, d, o, br);
         $display("rnd %0d: a=%02h b=%02h diff=%03h ovf=%0b brw=%0b", i, ra, rb, d, o, br);
         chk("rnd diff", d, ed);
         chk("rnd overflow", o, eo);
         chk("rnd borrow", br, ebr);
      end

      // Back-pressure with input noise during RUN and DONE.
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      a = 8'h33;
      b = 8'h44;
      @(negedge clk);
      lat = 0;
      while (!out_valid && lat < 100) begin
         a = W'($urandom);
         b = W'($urandom);
         @(negedge clk);
         lat++;
      end
      chk("bp latency", lat, W);
      held_d = diff;
      held_o = ovf;
      held_b = brw;
      chk("bp diff", held_d, 9'h1EF);
      for (int i = 0; i < 5; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         @(negedge clk);
         chk("bp out_valid held", out_valid, 1);
         chk("bp diff stable", diff, held_d);
         chk("bp ovf stable", ovf, held_o);
         chk("bp brw stable", brw, held_b);
         chk("bp in_ready low", in_ready, 0);
      end
      out_ready = 1'b1;
      a = 8'h11;
      b = 8'h01;
      @(negedge clk);
      chk("bp handshake out_valid", out_valid, 0);
      chk("bp in_ready after handshake", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp next accepted", in_ready, 0);
      wait_valid(lat);
      chk("bp next latency", lat, W);
      chk("bp next diff", diff, 9'h010);
      $display("backpressure: held diff=%03h next diff=%03h", held_d, diff);
      @(negedge clk);

      // Reset during bit 3 of an operation.
      in_valid = 1'b1;
      a = 8'h55;
      b = 8'h22;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrun out_valid", out_valid, 0);
      chk("midrun diff", diff, 0);
      chk("midrun overflow", ovf, 0);
      chk("midrun borrow", brw, 0);
      chk("midrun in_ready in reset", in_ready, 0);
      rst = 1'b0;
      #1;
      chk("midrun in_ready release", in_ready, 1);
      for (int i = 0; i < W + 2; i++) begin
         @(negedge clk);
         chk("aborted op silent", out_valid, 0);
      end
      run_op(8'd10, 8'd20, d, o, br);
      $display("after reset: a=0a b=14 diff=%03h ovf=%0b brw=%0b", d, o, br);
      chk("post-reset diff", d, 9'h1F6);
      chk("post-reset overflow", o, 0);
      chk("post-reset borrow", br, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
